// File: rtl/backbone_j_gen_seq.sv
// Per-index backbone term generator: floor(backbone * alpha[0][x_0] / alpha[j][x_j]) for j = START_J..J-1,
// using a registered multiplier, a radix-2 restoring divider and an AXI-Stream style tagged output.
module backbone_j_gen_seq #(
  parameter  int unsigned J       = 14,
  parameter  int unsigned A       = 2,
  parameter  int unsigned BB_W    = 32,
  parameter  int unsigned ALPHA_W = 8,
  parameter  int unsigned OUT_W   = 32,
  parameter  int unsigned START_J = 1,
  localparam int unsigned J_WIDTH = $clog2(J) + 1,
  localparam int unsigned A_WIDTH = $clog2(A) + 1,
  localparam int unsigned P_W     = BB_W + ALPHA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BB_W-1:0]            backbone,
  input  logic                       backbone_tvalid,
  output logic                       backbone_tready,
  input  logic [J*A_WIDTH-1:0]       x_initial,
  input  logic                       x_initial_tvalid,
  input  logic [J*A*ALPHA_W-1:0]     alpha_u,
  input  logic                       alpha_u_tvalid,
  output logic [OUT_W-1:0]           backbone_J_tdata,
  output logic                       backbone_J_tvalid,
  input  logic                       backbone_J_tready,
  output logic [J_WIDTH-1:0]         backbone_J_tindex,
  output logic                       backbone_J_tlast,
  output logic [1:0]                 backbone_J_tuser,
  output logic                       busy
);

  localparam int unsigned X_W   = J * A_WIDTH;
  localparam int unsigned AL_W  = J * A * ALPHA_W;
  localparam int unsigned CNT_W = $clog2(P_W + 1);
  localparam int unsigned QX_W  = (P_W > OUT_W) ? P_W : OUT_W;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MUL, S_DIV, S_OUT} state_e;

  state_e             state_q, state_d;
  logic [X_W-1:0]     x_hold_q, x_hold_d, x_job_q, x_job_d;
  logic [AL_W-1:0]    alpha_hold_q, alpha_hold_d, alpha_job_q, alpha_job_d;
  logic [BB_W-1:0]    bb_q, bb_d;
  logic [J_WIDTH-1:0] j_q, j_d;
  logic [ALPHA_W-1:0] m_q, m_d, dvs_q, dvs_d, rem_q, rem_d;
  logic               err_q, err_d;
  logic [P_W-1:0]     dv_q, dv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d, bb_tready_q, bb_tready_d;
  logic [OUT_W-1:0]   tdata_q, tdata_d;
  logic [J_WIDTH-1:0] tindex_q, tindex_d;
  logic [1:0]         tuser_q, tuser_d;

  logic [A_WIDTH-1:0] x0_c, xj_c;
  logic [ALPHA_W-1:0] m_sel_c, d_sel_c;
  logic               xj_bad_c;
  logic [ALPHA_W:0]   trial_c;
  logic               ge_c;
  logic [P_W-1:0]     quot_c;
  logic               sat_c;

  // Operand selection from the job snapshot; out-of-range selectors leave the operand at 0
  always_comb begin
    x0_c    = x_job_q[A_WIDTH-1:0];
    xj_c    = '0;
    m_sel_c = '0;
    d_sel_c = '0;
    for (int jj = 0; jj < int'(J); jj++) begin
      if (j_q == J_WIDTH'(jj)) xj_c = x_job_q[jj*A_WIDTH +: A_WIDTH];
    end
    for (int aa = 0; aa < int'(A); aa++) begin
      if (x0_c == A_WIDTH'(aa)) m_sel_c = alpha_job_q[aa*ALPHA_W +: ALPHA_W];
    end
    for (int jj = 0; jj < int'(J); jj++) begin
      for (int aa = 0; aa < int'(A); aa++) begin
        if (j_q == J_WIDTH'(jj) && xj_c == A_WIDTH'(aa))
          d_sel_c = alpha_job_q[(jj*A+aa)*ALPHA_W +: ALPHA_W];
      end
    end
    xj_bad_c = (xj_c >= A_WIDTH'(A));
  end

  // One restoring-division step; a zero divisor always subtracts, giving an all-ones quotient
  always_comb begin
    trial_c = {rem_q, dv_q[P_W-1]};
    ge_c    = (trial_c >= {1'b0, dvs_q});
    quot_c  = {dv_q[P_W-2:0], ge_c};
    sat_c   = (QX_W'(quot_c) > QX_W'({OUT_W{1'b1}}));
  end

  always_comb begin
    state_d      = state_q;
    x_hold_d     = x_initial_tvalid ? x_initial : x_hold_q;
    alpha_hold_d = alpha_u_tvalid ? alpha_u : alpha_hold_q;
    x_job_d      = x_job_q;
    alpha_job_d  = alpha_job_q;
    bb_d         = bb_q;
    j_d          = j_q;
    m_d          = m_q;
    dvs_d        = dvs_q;
    err_d        = err_q;
    dv_d         = dv_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tindex_d     = tindex_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;

    case (state_q)
      S_IDLE: begin
        if (backbone_tvalid) begin
          bb_d        = backbone;
          x_job_d     = x_hold_d;
          alpha_job_d = alpha_hold_d;
          j_d         = J_WIDTH'(START_J);
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        m_d     = m_sel_c;
        dvs_d   = xj_bad_c ? '0 : d_sel_c;
        err_d   = xj_bad_c || (d_sel_c == '0);
        state_d = S_MUL;
      end
      S_MUL: begin
        dv_d    = P_W'(bb_q) * P_W'(m_q);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        dv_d  = quot_c;
        rem_d = ge_c ? ALPHA_W'(trial_c - {1'b0, dvs_q}) : ALPHA_W'(trial_c);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(P_W - 1)) begin
          tvalid_d = 1'b1;
          // An erroneous term is flagged only as an error, never additionally as saturated
          tdata_d  = (sat_c || err_q) ? {OUT_W{1'b1}} : OUT_W'(quot_c);
          tuser_d  = {sat_c & ~err_q, err_q};
          tindex_d = j_q;
          tlast_d  = (j_q == J_WIDTH'(J - 1));
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (backbone_J_tready) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            state_d = S_IDLE;
          end else begin
            j_d     = j_q + J_WIDTH'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    bb_tready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_hold_q     <= '0;
      alpha_hold_q <= '0;
      x_job_q      <= '0;
      alpha_job_q  <= '0;
      bb_q         <= '0;
      j_q          <= '0;
      m_q          <= '0;
      dvs_q        <= '0;
      err_q        <= 1'b0;
      dv_q         <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tindex_q     <= '0;
      tlast_q      <= 1'b0;
      tuser_q      <= '0;
      busy_q       <= 1'b0;
      bb_tready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_hold_q     <= x_hold_d;
      alpha_hold_q <= alpha_hold_d;
      x_job_q      <= x_job_d;
      alpha_job_q  <= alpha_job_d;
      bb_q         <= bb_d;
      j_q          <= j_d;
      m_q          <= m_d;
      dvs_q        <= dvs_d;
      err_q        <= err_d;
      dv_q         <= dv_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      tvalid_q     <= tvalid_d;
      tdata_q      <= tdata_d;
      tindex_q     <= tindex_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      busy_q       <= busy_d;
      bb_tready_q  <= bb_tready_d;
    end
  end

  assign backbone_tready   = bb_tready_q;
  assign backbone_J_tvalid = tvalid_q;
  assign backbone_J_tdata  = tdata_q;
  assign backbone_J_tindex = tindex_q;
  assign backbone_J_tlast  = tlast_q;
  assign backbone_J_tuser  = tuser_q;
  assign busy              = busy_q;

endmodule

// File: doc/backbone_j_gen_seq.md
# backbone_j_gen_seq

Parametrised, backpressure-aware generator of the per-index backbone terms: for every index j from START_J to J-1 it computes floor(backbone * alpha[0][x_0] / alpha[j][x_j]) using an internal registered multiplier and a sequential restoring divider, then emits one tagged result per j on an AXI-Stream-style output. It sits between the backbone source and the per-J consumers, replacing the fixed-width, IP-based, no-backpressure generator. It adds:
- generic widths;
- input snapshotting;
- divide-by-zero, index-error and saturation flags;
- output index and tlast tagging.

## Interface
- J, 14, number of indices (J >= 2)
- A, 2, columns per alpha row
- BB_W, 32, backbone width
- ALPHA_W, 8, alpha element width
- OUT_W, 32, result width
- START_J, 1, first index emitted (0 or 1)
- Derived: J_WIDTH = $clog2(J)+1, A_WIDTH = $clog2(A)+1, P_W = BB_W+ALPHA_W
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- backbone  in  BB_W  backbone value
- backbone_tvalid  in  1  backbone offered
- backbone_tready  out  1  high only in IDLE
- x_initial  in  J*A_WIDTH  column selector per index; field j at [j*A_WIDTH +: A_WIDTH]
- x_initial_tvalid  in  1  load x_initial holding register
- alpha_u  in  J*A*ALPHA_W  element (j,a) at [(j*A+a)*ALPHA_W +: ALPHA_W]
- alpha_u_tvalid  in  1  load alpha holding register
- backbone_J_tdata  out  OUT_W  result
- backbone_J_tvalid  out  1  result valid
- backbone_J_tready  in  1  consumer ready
- backbone_J_tindex  out  J_WIDTH  j of current result
- backbone_J_tlast  out  1  high when tindex == J-1
- backbone_J_tuser  out  2  [0] zero divisor or index error, [1] saturated
- busy  out  1  high when not IDLE

## Operation
- Holding registers:
  - x_initial and alpha_u are captured on their tvalid.
  - On backbone acceptance (backbone_tvalid & backbone_tready), backbone and both holding registers are snapshotted into the job. A same-cycle x_initial_tvalid or alpha_u_tvalid uses the new input value.
  - Later holding-register loads do not affect a running job.
- FSM: IDLE -> FETCH -> MUL -> DIV -> OUT.
  - IDLE -> FETCH on acceptance; j = START_J.
  - FETCH: select multiplier m = alpha[0][x_0] and divisor d = alpha[j][x_j]. If x_0 >= A, m is forced to 0. If x_j >= A, d is forced to 0 and err is set. err is also set if d == 0.
  - MUL: product p = backbone * m, P_W bits unsigned, registered.
  - DIV: restoring radix-2, one quotient bit per cycle, exactly P_W cycles regardless of operands. A zero divisor naturally yields an all-ones quotient.
  - OUT: tvalid held with all output fields stable until tready. On the handshake: if j == J-1 go to IDLE, else j++ and go to FETCH.
- Output formatting: if quotient > 2^OUT_W-1, tdata = all ones and tuser[1] = 1; else tdata = quotient[OUT_W-1:0]. tuser[0] = err.
- Arithmetic is unsigned throughout; no rounding (floor).

## Timing
- Reset values (asynchronous):
  - outputs: tvalid 0, tdata 0, tindex 0, tlast 0, tuser 0, busy 0, backbone_tready 1.
  - internal: state IDLE, holding registers 0.
- Reset asserted mid-job aborts immediately. No partial result is emitted after release.
- Latency: the first tvalid rises after rising edge P_W+2 counted from the accepting edge (42 at defaults).
- Each subsequent tvalid rises P_W+2 edges after the previous output handshake edge.
- tvalid deasserts on the handshake edge. No bubble-free back-to-back output is required.
- backbone_tready = (state == IDLE). Backbone offered while busy is held off, not dropped.
- A new job may be accepted in the cycle after the tlast handshake.
- Number of results per job: J-START_J.

## Test plan
Common setup for scenarios 1-3: J=4, A=2, START_J=1, backbone=1000, x = {x0=1, x1=0, x2=1, x3=0}, alpha[0][1]=10, alpha[1][0]=4, alpha[2][1]=3, alpha[3][0]=0, tready held high.

- Basic: three results:
  - tindex 1: tdata 2500, tuser 00.
  - tindex 2: tdata 3333, tuser 00.
  - tindex 3: tdata 0xFFFFFFFF, tuser 01, tlast 1.
  - First tvalid 42 cycles after acceptance.
- Saturation: backbone=0xFFFFFFFF, alpha[0][x0]=255, divisor 1 -> tdata 0xFFFFFFFF, tuser 10.
- Index error: x2 = 2 (>= A) -> tindex 2 yields tdata 0xFFFFFFFF, tuser 01. Other indices are unaffected.
- Backpressure and hold-off:
  - tready held low 10 cycles at tindex 1 -> tdata, tindex and tuser stable, no result lost.
  - A second backbone_tvalid during the job sees backbone_tready=0. It is accepted only after the tlast handshake.
- Snapshot: change alpha_u and x_initial mid-job -> the remaining results use the old values. The next job uses the new values.
- Reset mid-DIV: rst_n low 2 cycles during tindex 2 -> outputs go to reset values at once, busy 0, no stray tvalid. The next job's results are correct.
